// File: rtl/bfloat16_rf_max.sv
// bfloat16_rf_max: scans a wrapping window of a bfloat16 register file and reports the largest
// non-NaN value, its address, and whether any NaN was seen.
module bfloat16_rf_max #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_x,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_re,
    input  logic [DATA_W-1:0] rf_dout,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max_val,
    output logic [ADDR_W-1:0] max_idx,
    output logic              nan_flag,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;
    localparam logic [DATA_W-1:0] NEG_INF = {1'b1, 8'hFF, {(DATA_W-9){1'b0}}};
    state_t state;
    logic [ADDR_W-1:0] rem;
    logic is_nan, take, bad_count;
    // Sign-magnitude to monotonic unsigned key: larger key means larger value.
    function automatic logic [DATA_W-1:0] key(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? ~x : x ^ {1'b1, {(DATA_W-1){1'b0}}};
    endfunction
    always_comb begin
        is_nan = rf_dout[DATA_W-2 -: 8] == 8'hFF && rf_dout[DATA_W-10:0] != '0;
        take = !is_nan && key(rf_dout) > key(max_val);
        bad_count = count == '0 || count > (ADDR_W+1)'(DEPTH);
    end
    always_ff @(posedge clk) begin
        if (rst_x) begin
            state <= IDLE;
            rem <= '0;
            rf_addr <= '0;
            rf_re <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            max_val <= '0;
            max_idx <= '0;
            nan_flag <= 1'b0;
            err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    max_val <= NEG_INF;
                    max_idx <= base_addr;
                    nan_flag <= 1'b0;
                    err <= bad_count;
                    if (bad_count) begin
                        done <= 1'b1;
                        state <= FIN;
                    end else begin
                        rf_addr <= base_addr;
                        rf_re <= 1'b1;
                        busy <= 1'b1;
                        rem <= count[ADDR_W-1:0] - 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (take) begin
                        max_val <= rf_dout;
                        max_idx <= rf_addr;
                    end
                    if (is_nan) nan_flag <= 1'b1;
                    if (rem == '0) begin
                        rf_re <= 1'b0;
                        busy <= 1'b0;
                        done <= 1'b1;
                        state <= FIN;
                    end else begin
                        rf_addr <= rf_addr + 1'b1;
                        rem <= rem - 1'b1;
                    end
                end
                FIN: begin
                    done <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/bfloat16_rf_max.md
Name: bfloat16_rf_max

Overview:
- Downstream consumer of the 32-entry bfloat16 register file (combinational read: dout valid in the same cycle as addr).
- On start, walks a contiguous, wrapping window of RF addresses one entry per cycle and finds the maximum bfloat16 value and its address.
- Feeds normalisation/scaling stages that need a per-block maximum.

Parameters:
- DATA_W, 16, bfloat16 word width
- ADDR_W, 5, RF address width
- DEPTH, 32, RF entries (2**ADDR_W)

Ports:
- clk  in  1  system clock, rising edge
- rst_x  in  1  reset: synchronous, active-high (rst_x=1 resets on the next clk edge)
- start  in  1  single-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first RF address to scan; sampled with start
- count  in  ADDR_W+1  number of entries, 0..32; sampled with start
- rf_addr  out  ADDR_W  RF read address; driven to RF addr
- rf_re  out  1  high when rf_addr is a live scan read
- rf_dout  in  DATA_W  RF read data (combinational from rf_addr)
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse; results valid from this cycle
- max_val  out  DATA_W  largest non-NaN value scanned
- max_idx  out  ADDR_W  RF address of max_val
- nan_flag  out  1  at least one NaN was scanned
- err  out  1  count==0, or count>32 (clamped case is illegal)

Behaviour:
- Reset: every output is 0 (rf_addr=0, rf_re=0, busy=0, done=0, max_val=0, max_idx=0, nan_flag=0, err=0). State=IDLE. Reset mid-scan aborts immediately. No done pulse is produced.
- FSM states: IDLE, SCAN, FIN.
- IDLE + start with 1<=count<=32:
  - Latch base and count.
  - Clear nan_flag and err. Set the internal best key to the minimum (max_val=0xFF80, i.e. -inf; max_idx=base).
  - Go to SCAN.
- IDLE + start with count==0 or count>32:
  - Go to FIN with err=1, max_val=0xFF80, max_idx=base_addr, nan_flag=0.
- SCAN:
  - rf_addr=(base+i) mod 32 for i=0..count-1, with rf_re=1 and busy=1.
  - rf_dout is evaluated in the same cycle.
  - After i=count-1, go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- Timing: start at cycle T gives busy high T+1..T+count and done at T+count+1. Total latency is count+1 cycles.
- In IDLE and FIN, rf_addr holds its last value and rf_re=0.
- Results (max_val, max_idx, nan_flag, err) hold until the next accepted start.
- start while busy or in FIN is ignored, with no queuing.
- Compare rule: map each value to an unsigned key.
  - sign=0: key = x ^ 0x8000
  - sign=1: key = ~x
  - Greater key means greater value, so -0 (0x8000) < +0 (0x0000) and -inf is the minimum.
- Replace the current max only on a strictly greater key, so ties keep the first-scanned address.
- NaN (exp==0xFF, mantissa!=0): never compared or stored; sets nan_flag.
- The max_val/max_idx initial value is the -inf sentinel.
  - If every scanned entry is NaN, the result is max_val=0xFF80, max_idx=base, nan_flag=1.
  - A genuine -inf entry at base gives an identical result. This ambiguity is accepted.
- Denormals are compared by raw key. No flushing.
- Address wrap: base=30, count=4 reads 30, 31, 0, 1.
- Running max is updated with a registered write-back. The output registers are the running registers, visible during SCAN, but valid only at done.
- rst_x asserted in the same cycle as start: reset wins.

Test Plan:
- Load RF[0..3]=0x3F80, 0x4000, 0xC040, 0x3F00; start base=0, count=4 at T -> busy T+1..T+4, done at T+5, max_val=0x4000, max_idx=1, nan_flag=0, err=0.
- Wrap: RF[30]=0x4080, RF[31]=0x3F80, RF[0]=0x40A0, RF[1]=0xBF80; base=30, count=4 -> rf_addr sequence 30, 31, 0, 1; max_val=0x40A0, max_idx=0.
- NaN/inf/zeros: RF[4..7]=0x7FC0, 0x8000, 0x0000, 0xFF80; base=4, count=4 -> max_val=0x0000, max_idx=6, nan_flag=1. Then RF[5]=0x7F80, rescan -> max_val=0x7F80, max_idx=5.
- Ties and all-negative: RF[8..10]=0xC000, 0xBF80, 0xBF80; base=8, count=3 -> max_val=0xBF80, max_idx=9.
- Edge counts:
  - count=0 -> done at T+1, err=1, max_val=0xFF80, max_idx=base_addr, busy never asserted.
  - count=32, base=17, RF all 0x3F80 except RF[16]=0x4100 -> done at T+33, max_val=0x4100, max_idx=16.
- Control: start pulsed again mid-scan -> ignored, one done only. rst_x=1 at T+2 of a count=8 scan -> next cycle all outputs 0, state IDLE, no done.
